tick_rate_ctrl: RTL



---
 rtl/tick_rate_ctrl.sv | 132 +++++++++++++
 1 files changed

// File: rtl/tick_rate_ctrl.sv
// tick_rate_ctrl: four-rate timebase scheduler producing a 50% out_clk and a one-cycle tick.
// Define TICK_CNT_EN to add the 16-bit tick_count output.
`timescale 1ns/1ps
module tick_rate_ctrl #(
  parameter int unsigned CNT_W = 31,
  parameter int unsigned HALF0 = 25000000,
  parameter int unsigned HALF1 = 250000,
  parameter int unsigned HALF2 = 2500000,
  parameter int unsigned HALF3 = 25000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run_en,
  input  logic [1:0] sel_in,
  input  logic       sel_valid,
  output logic       sel_ready,
  output logic [1:0] cur_sel,
  output logic       out_clk,
  output logic       tick,
  output logic       running
`ifdef TICK_CNT_EN
  ,
  output logic [15:0] tick_count
`endif
);

  localparam logic [1:0] ST_STOP   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_SWITCH = 2'd2;

  logic [1:0]       state;
  logic [1:0]       next_state;
  logic [1:0]       pend_sel;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] half_m1;
  logic             accept;
  logic             at_end;
  logic             boundary;
  logic             apply_sel;
  logic             release_same;

  // Terminal count of the currently applied rate
  always_comb begin
    half_m1 = CNT_W'(HALF0 - 1);
    case (cur_sel)
      2'd1:    half_m1 = CNT_W'(HALF1 - 1);
      2'd2:    half_m1 = CNT_W'(HALF2 - 1);
      2'd3:    half_m1 = CNT_W'(HALF3 - 1);
      default: half_m1 = CNT_W'(HALF0 - 1);
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_STOP;
    else     state <= next_state;
  end

  // Next state plus the handshake/boundary strobes shared by the datapath
  always_comb begin
    next_state   = state;
    accept       = sel_valid && sel_ready;
    at_end       = (cnt == half_m1);
    boundary     = (state != ST_STOP) && at_end && out_clk;
    apply_sel    = 1'b0;
    release_same = 1'b0;
    case (state)
      ST_STOP: begin
        // An outstanding request is applied before the timebase may start
        apply_sel = !sel_ready;
        if (sel_ready && !accept && run_en) next_state = ST_RUN;
      end
      ST_RUN: begin
        // Only a same-rate request can still be outstanding here
        release_same = !sel_ready;
        if (boundary && !run_en)                 next_state = ST_STOP;
        else if (accept && (sel_in != cur_sel))  next_state = ST_SWITCH;
      end
      ST_SWITCH: begin
        if (boundary) begin
          apply_sel  = 1'b1;
          next_state = run_en ? ST_RUN : ST_STOP;
        end
      end
      default: next_state = ST_STOP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_sel  <= 2'd0;
      cur_sel   <= 2'd0;
      sel_ready <= 1'b1;
    end else begin
      if (accept) begin
        pend_sel  <= sel_in;
        sel_ready <= 1'b0;
      end else if (apply_sel || release_same) begin
        sel_ready <= 1'b1;
      end
      if (apply_sel) cur_sel <= pend_sel;
    end
  end

  // Divider: the toggle at a boundary always lands out_clk at 0 with cnt cleared
  always_ff @(posedge clk) begin
    if (rst || (state == ST_STOP)) begin
      cnt     <= '0;
      out_clk <= 1'b0;
      tick    <= 1'b0;
    end else if (at_end) begin
      cnt     <= '0;
      out_clk <= ~out_clk;
      tick    <= ~out_clk;
    end else begin
      cnt     <= cnt + CNT_W'(1);
      tick    <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) running <= 1'b0;
    else     running <= (next_state != ST_STOP);
  end

`ifdef TICK_CNT_EN
  always_ff @(posedge clk) begin
    if (rst || (apply_sel && (pend_sel != cur_sel))) tick_count <= 16'd0;
    else if (tick)                                   tick_count <= tick_count + 16'd1;
  end
`endif

endmodule
